// File: rtl/adder_rca_pkg.sv
`default_nettype none
// ============================================================================
// adder_rca_pkg -- shared constants for the ripple-carry adder.  Rev 1.0
// ============================================================================
package adder_rca_pkg;

    localparam int ADDER_W_DEFAULT = 9;
    localparam int ADDER_W_MIN     = 1;
    localparam int ADDER_W_MAX     = 64;

endpackage : adder_rca_pkg
`default_nettype wire

// File: rtl/adder_rca_full_adder.sv
`default_nettype none
// ============================================================================
// adder_rca_full_adder -- one-bit combinational full-adder cell.  Rev 1.0
// ============================================================================
module adder_rca_full_adder
    import adder_rca_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : adder_rca_full_adder
`default_nettype wire

// File: rtl/adder_rca.sv
`default_nettype none
// ============================================================================
// adder_rca -- W-bit ripple-carry adder, {carry_out, sum} registered.  Rev 1.0
// ============================================================================
module adder_rca
    import adder_rca_pkg::*;
#(
    parameter int W = ADDER_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         carry_in,
    output logic [W-1:0] sum,
    output logic         carry_out
);

    logic [W:0]   carry;
    logic [W-1:0] sum_comb;

    assign carry[0] = carry_in;

    // Deliberately a plain ripple chain: the carry crosses all W cells.
    for (genvar i = 0; i < W; i++) begin : g_cell
        adder_rca_full_adder u_fa (
            .a    (x[i]),
            .b    (y[i]),
            .cin  (carry[i]),
            .s    (sum_comb[i]),
            .cout (carry[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            sum       <= sum_comb;
            carry_out <= carry[W];
        end
    end

endmodule : adder_rca
`default_nettype wire

// File: tb/tb_adder_rca.sv
`default_nettype none
// ============================================================================
// tb_adder_rca -- directed and random checks of adder_rca at W=9, 1 and 16.
// ============================================================================
module tb_adder_rca;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [8:0]  x9 = '0, y9 = '0, sum9;
    logic        ci9 = 1'b0, co9;
    logic        x1 = 1'b0, y1 = 1'b0, sum1;
    logic        ci1 = 1'b0, co1;
    logic [15:0] x16 = '0, y16 = '0, sum16;
    logic        ci16 = 1'b0, co16;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    adder_rca #(.W(9)) dut9 (
        .clk(clk), .rst(rst), .x(x9), .y(y9), .carry_in(ci9),
        .sum(sum9), .carry_out(co9)
    );

    adder_rca #(.W(1)) dut1 (
        .clk(clk), .rst(rst), .x(x1), .y(y1), .carry_in(ci1),
        .sum(sum1), .carry_out(co1)
    );

    adder_rca #(.W(16)) dut16 (
        .clk(clk), .rst(rst), .x(x16), .y(y16), .carry_in(ci16),
        .sum(sum16), .carry_out(co16)
    );

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed {co,sum}=0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one operation on the W=9 instance and check it one edge later.
    task automatic op9(input string tag, input logic r, input logic [8:0] a,
                       input logic [8:0] b, input logic c,
                       input logic [8:0] exp_sum, input logic exp_co);
        rst = r; x9 = a; y9 = b; ci9 = c;
        @(posedge clk); #1;
        check(tag, {7'd0, co9, sum9}, {7'd0, exp_co, exp_sum});
    endtask

    initial begin
        int rst_cycle;
        logic [16:0] e9, e1, e16;

        @(posedge clk); #1;

        op9("reset_cycle1", 1'b1, 9'h1FF, 9'h1FF, 1'b1, 9'd0, 1'b0);
        op9("reset_cycle2", 1'b1, 9'h1FF, 9'h1FF, 1'b1, 9'd0, 1'b0);

        op9("0+146+1",      1'b0, 9'd0,   9'd146, 1'b1, 9'd147, 1'b0);
        op9("1+1+0",        1'b0, 9'd1,   9'd1,   1'b0, 9'd2,   1'b0);
        op9("5+3+0",        1'b0, 9'd5,   9'd3,   1'b0, 9'd8,   1'b0);
        op9("511+1+0",      1'b0, 9'd511, 9'd1,   1'b0, 9'd0,   1'b1);
        op9("341+170+0",    1'b0, 9'd341, 9'd170, 1'b0, 9'd511, 1'b0);
        op9("5+3+1",        1'b0, 9'd5,   9'd3,   1'b1, 9'd9,   1'b0);
        op9("511+1+1",      1'b0, 9'd511, 9'd1,   1'b1, 9'd1,   1'b1);
        op9("341+170+1",    1'b0, 9'd341, 9'd170, 1'b1, 9'd0,   1'b1);
        op9("0+1+1",        1'b0, 9'd0,   9'd1,   1'b1, 9'd2,   1'b0);
        op9("sub_5-3",      1'b0, 9'd5,   9'd508, 1'b1, 9'd2,   1'b1);
        op9("sub_0-1",      1'b0, 9'd0,   9'd510, 1'b1, 9'd511, 1'b0);
        op9("511+511+1",    1'b0, 9'd511, 9'd511, 1'b1, 9'd511, 1'b1);
        op9("mid_reset",    1'b1, 9'd100, 9'd200, 1'b1, 9'd0,   1'b0);
        op9("after_reset",  1'b0, 9'd100, 9'd200, 1'b1, 9'd301, 1'b0);

        // Back-to-back random traffic on all widths with one reset cycle.
        rst_cycle = $urandom_range(10, 989);
        for (int i = 0; i < 1000; i++) begin
            rst  = (i == rst_cycle);
            x9   = 9'($urandom);  y9  = 9'($urandom);  ci9  = 1'($urandom);
            x1   = 1'($urandom);  y1  = 1'($urandom);  ci1  = 1'($urandom);
            x16  = 16'($urandom); y16 = 16'($urandom); ci16 = 1'($urandom);
            if (rst) begin
                e9 = '0; e1 = '0; e16 = '0;
            end else begin
                e9  = 17'({1'b0, x9})  + 17'({1'b0, y9})  + 17'(ci9);
                e1  = 17'({1'b0, x1})  + 17'({1'b0, y1})  + 17'(ci1);
                e16 = 17'({1'b0, x16}) + 17'({1'b0, y16}) + 17'(ci16);
            end
            @(posedge clk); #1;
            check("rand_w9",  {7'd0, co9, sum9},    e9);
            check("rand_w1",  {15'd0, co1, sum1},   e1);
            check("rand_w16", {co16, sum16},        e16);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_adder_rca
`default_nettype wire
